// File: rtl/relu_pkg.sv
// Shared definitions for the ReLU backprop slice.
//   DATA_W     : bits per lane (signed 2's-complement)
//   MAX_LANES  : upper bound on lanes a vector may carry through lane_sign
//   lane_sign  : sign bit of lane i of a (zero-extended) packed vector
package relu_pkg;

    localparam int DATA_W    = 8;
    localparam int MAX_LANES = 256;
    localparam int MAX_VEC_W = DATA_W * MAX_LANES;

    // Returns bit 8i+DATA_W-1 of vec, i.e. 1 when lane i is negative.
    function automatic logic lane_sign(input logic [MAX_VEC_W-1:0] vec,
                                       input int unsigned          i);
        return vec[DATA_W * i + DATA_W - 1];
    endfunction

endpackage

// File: rtl/relu_mask_fifo.sv
// Synchronous FIFO holding one sign mask per forward vector.
//   clock  : rising-edge clock
//   reset  : synchronous active-low reset (clears pointers and count)
//   push   : write din (ignored when full)
//   din    : mask to store
//   pop    : discard the entry at dout (ignored when empty)
//   dout   : oldest entry, valid whenever !empty
//   full   : count == DEPTH
//   empty  : count == 0
//   count  : entries currently stored
module relu_mask_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is not reset: clearing the pointers discards its contents.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/relu_backprop.sv
// Backward pass of an 8-bit ReLU layer.
// Forward vectors leave one sign bit per lane in a mask FIFO; each gradient
// vector pops the oldest mask and has its negative-input lanes zeroed.
//   clock      : rising-edge clock
//   reset      : synchronous active-low reset
//   fwd_valid  / fwd_in  / fwd_ready : forward input vectors (mask push)
//   bwd_valid  / bwd_grad / bwd_ready: incoming gradient vectors (mask pop)
//   out_valid  / out_grad / out_ready: gated gradient, one register stage
//   mask_count : masks currently stored
//   underflow  : sticky, set when a gradient is offered with no mask stored
module relu_backprop
    import relu_pkg::*;
#(
    parameter int SIZE  = -1,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       fwd_valid,
    input  logic [DATA_W*SIZE-1:0]     fwd_in,
    output logic                       fwd_ready,
    input  logic                       bwd_valid,
    input  logic [DATA_W*SIZE-1:0]     bwd_grad,
    output logic                       bwd_ready,
    output logic                       out_valid,
    output logic [DATA_W*SIZE-1:0]     out_grad,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] mask_count,
    output logic                       underflow
);

    localparam int VW = DATA_W * SIZE;

    if (SIZE <= 0) begin : g_bad_size
        $error("relu_backprop: SIZE must be set > 0");
    end
    if (SIZE > MAX_LANES) begin : g_too_wide
        $error("relu_backprop: SIZE exceeds relu_pkg::MAX_LANES");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("relu_backprop: DEPTH must be >= 2");
    end

    logic                 running;   // low during and one cycle after reset
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [SIZE-1:0]      mask_in;
    logic [SIZE-1:0]      mask_head;
    logic                 push;
    logic                 pop;
    logic [MAX_VEC_W-1:0] fwd_ext;
    logic [VW-1:0]        gated;

    assign fwd_ready = running && !fifo_full;
    assign bwd_ready = !fifo_empty && (!out_valid || out_ready);
    assign push      = fwd_valid && fwd_ready;
    assign pop       = bwd_valid && bwd_ready;

    always_comb begin
        fwd_ext         = '0;
        fwd_ext[VW-1:0] = fwd_in;
    end

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        assign mask_in[i] = lane_sign(fwd_ext, i);
        // Zero input is non-negative, so its gradient passes.
        assign gated[DATA_W*i +: DATA_W] =
            mask_head[i] ? '0 : bwd_grad[DATA_W*i +: DATA_W];
    end

    relu_mask_fifo #(
        .WIDTH (SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (mask_in),
        .pop   (pop),
        .dout  (mask_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (mask_count)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            running   <= 1'b0;
            out_valid <= 1'b0;
            out_grad  <= '0;
            underflow <= 1'b0;
        end else begin
            running <= 1'b1;
            if (bwd_valid && fifo_empty) begin
                underflow <= 1'b1;
            end
            if (pop) begin
                out_valid <= 1'b1;
                out_grad  <= gated;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_relu_backprop.sv
// Randomised bench for relu_backprop (SIZE=4, DEPTH=4) against a
// queue-based behavioural model, plus literal spot checks.
module tb_relu_backprop;

    localparam int SIZE  = 4;
    localparam int DEPTH = 4;
    localparam int VW    = 8 * SIZE;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          fwd_valid = 1'b0;
    logic [VW-1:0] fwd_in = '0;
    logic          fwd_ready;
    logic          bwd_valid = 1'b0;
    logic [VW-1:0] bwd_grad = '0;
    logic          bwd_ready;
    logic          out_valid;
    logic [VW-1:0] out_grad;
    logic          out_ready = 1'b1;
    logic [CW-1:0] mask_count;
    logic          underflow;

    int compared   = 0;
    int mismatched = 0;
    bit check_en   = 1'b0;

    relu_backprop #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .fwd_valid  (fwd_valid),
        .fwd_in     (fwd_in),
        .fwd_ready  (fwd_ready),
        .bwd_valid  (bwd_valid),
        .bwd_grad   (bwd_grad),
        .bwd_ready  (bwd_ready),
        .out_valid  (out_valid),
        .out_grad   (out_grad),
        .out_ready  (out_ready),
        .mask_count (mask_count),
        .underflow  (underflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [SIZE-1:0] m_q[$];
    bit              m_run   = 1'b0;
    bit              m_ov    = 1'b0;
    logic [VW-1:0]   m_og    = '0;
    bit              m_uf    = 1'b0;

    function automatic logic [SIZE-1:0] negatives(input logic [VW-1:0] v);
        logic signed [7:0] b;
        logic [SIZE-1:0]   n;
        for (int i = 0; i < SIZE; i++) begin
            b    = v[8*i +: 8];
            n[i] = (b < 0);
        end
        return n;
    endfunction

    function automatic logic [VW-1:0] apply_mask(input logic [SIZE-1:0] neg, input logic [VW-1:0] g);
        logic [VW-1:0] r;
        for (int i = 0; i < SIZE; i++) begin
            r[8*i +: 8] = neg[i] ? 8'h00 : g[8*i +: 8];
        end
        return r;
    endfunction

    function automatic bit m_fwd_ready();
        return m_run && (m_q.size() != DEPTH);
    endfunction

    function automatic bit m_bwd_ready();
        return (m_q.size() != 0) && (!m_ov || out_ready);
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            m_q.delete();
            m_run = 1'b0;
            m_ov  = 1'b0;
            m_og  = '0;
            m_uf  = 1'b0;
        end else begin
            bit fr, br;
            fr = m_fwd_ready();
            br = m_bwd_ready();
            if (bwd_valid && m_q.size() == 0) m_uf = 1'b1;
            if (bwd_valid && br) begin
                m_og = apply_mask(m_q.pop_front(), bwd_grad);
                m_ov = 1'b1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            if (fwd_valid && fr) m_q.push_back(negatives(fwd_in));
            m_run = 1'b1;
        end
    end

    always @(negedge clock) begin
        if (check_en) begin
            chk("fwd_ready",  64'(fwd_ready),  64'(m_fwd_ready()));
            chk("bwd_ready",  64'(bwd_ready),  64'(m_bwd_ready()));
            chk("out_valid",  64'(out_valid),  64'(m_ov));
            chk("out_grad",   64'(out_grad),   64'(m_og));
            chk("mask_count", 64'(mask_count), 64'(m_q.size()));
            chk("underflow",  64'(underflow),  64'(m_uf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        fwd_valid = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (mask_count == '0 && !out_valid) break;
            bwd_valid = (mask_count != '0);
            bwd_grad  = $urandom;
            step();
        end
        bwd_valid = 1'b0;
        chk("drain_empty", 64'(mask_count), 64'd0);
        chk("drain_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        // 1: reset with both valids asserted
        reset = 1'b0; fwd_valid = 1'b1; bwd_valid = 1'b1; out_ready = 1'b1;
        fwd_in = $urandom; bwd_grad = $urandom;
        step();
        check_en = 1'b1;
        step(); step();
        chk("rst_fwd_ready", 64'(fwd_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_grad",  64'(out_grad),  64'd0);
        chk("rst_count",     64'(mask_count), 64'd0);
        chk("rst_underflow", 64'(underflow), 64'd0);
        fwd_valid = 1'b0; bwd_valid = 1'b0;
        reset = 1'b1;
        step();
        chk("post_rst_fwd_ready", 64'(fwd_ready), 64'd1);

        // 2: basic gate
        fwd_valid = 1'b1; fwd_in = 32'h80_00_7F_FF;
        step();
        fwd_valid = 1'b0;
        chk("basic_count", 64'(mask_count), 64'd1);
        bwd_valid = 1'b1; bwd_grad = 32'h11_22_33_44;
        step();
        bwd_valid = 1'b0;
        chk("basic_out_valid", 64'(out_valid), 64'd1);
        chk("basic_out_grad",  64'(out_grad),  64'h00_22_33_00);
        drain();

        // 3: order and wrap with concurrent push and pop
        fwd_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            fwd_in    = {$urandom} ^ {8'(k << 7), 8'(k << 6), 8'(k << 5), 8'(k << 4)};
            bwd_valid = (k % 2 == 1);
            bwd_grad  = $urandom;
            step();
        end
        drain();

        // 4: full, then underflow
        chk("pre_underflow", 64'(underflow), 64'd0);
        fwd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            fwd_in = $urandom;
            step();
        end
        chk("full_count", 64'(mask_count), 64'd4);
        chk("full_fwd_ready", 64'(fwd_ready), 64'd0);
        fwd_valid = 1'b0;
        drain();
        bwd_valid = 1'b1;
        step();
        chk("empty_bwd_ready", 64'(bwd_ready), 64'd0);
        chk("underflow_set", 64'(underflow), 64'd1);
        bwd_valid = 1'b0;
        step();
        chk("underflow_sticky", 64'(underflow), 64'd1);

        // 5: backpressure with two masks queued
        fwd_valid = 1'b1;
        step(); fwd_in = $urandom; step();
        fwd_valid = 1'b0;
        out_ready = 1'b0; bwd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bwd_grad = $urandom;
            step();
        end
        chk("bp_count", 64'(mask_count), 64'd1);
        chk("bp_bwd_ready", 64'(bwd_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        bwd_valid = 1'b0;
        drain();

        // random traffic
        for (int k = 0; k < 400; k++) begin
            fwd_valid = ($urandom % 3) != 0;
            fwd_in    = $urandom;
            bwd_valid = ($urandom % 2) != 0;
            bwd_grad  = $urandom;
            out_ready = ($urandom % 4) != 0;
            step();
        end
        drain();

        // 6: reset mid-operation
        fwd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            fwd_in = $urandom;
            step();
        end
        fwd_valid = 1'b0;
        out_ready = 1'b0; bwd_valid = 1'b1; bwd_grad = $urandom;
        step();
        bwd_valid = 1'b0;
        chk("mid_count", 64'(mask_count), 64'd3);
        chk("mid_out_valid", 64'(out_valid), 64'd1);
        reset = 1'b0;
        step();
        chk("mid_rst_count", 64'(mask_count), 64'd0);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        reset = 1'b1; out_ready = 1'b1; bwd_valid = 1'b1;
        step();
        chk("mid_rst_bwd_ready", 64'(bwd_ready), 64'd0);
        step();
        chk("mid_rst_no_accept", 64'(out_valid), 64'd0);
        bwd_valid = 1'b0;
        step();

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
